// File: rtl/seven_segment_decoder.sv
// Decodes strobed active-low seven-segment scan traffic back into per-position BCD digits and dot flags.
// Commit lands one edge after a sample run reaches STABLE_CYCLES; inputs are observed passively with no backpressure.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_1Hz,
  input  logic        rst,
  input  logic [7:0]  pos,
  input  logic [7:0]  segments,
  output logic [31:0] digit,
  output logic [7:0]  dot,
  output logic [7:0]  valid,
  output logic        frame_done,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [7:0]    samp_pos;
  logic [7:0]    samp_seg;
  logic [3:0]    stab_cnt;
  logic          committed;
  logic [7:0]    seen;
  logic [TW-1:0] tcnt;

  logic [3:0] zcnt;
  logic [2:0] idx;
  logic       same;
  logic       stable_ok;
  logic       commit;
  logic [3:0] dec_digit;
  logic       dec_ill;
  logic       dec_dot;
  logic [7:0] seen_nxt;

  always_comb begin
    zcnt = '0;
    idx  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!samp_pos[i]) begin
        zcnt = zcnt + 4'd1;
        idx  = 3'(i);
      end
    end
  end

  always_comb begin
    dec_ill = 1'b0;
    case (samp_seg[7:1])
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      7'b1111111: dec_digit = 4'hF;
      default: begin
        dec_digit = 4'hE;
        dec_ill   = 1'b1;
      end
    endcase
  end

  // A blank position never reports a dot, even if dp is driven low.
  assign dec_dot   = ~samp_seg[0] & (samp_seg[7:1] != 7'b1111111);
  assign same      = ({pos, segments} == {samp_pos, samp_seg});
  assign stable_ok = ({1'b0, stab_cnt} + 5'd1) >= 5'(STABLE_CYCLES);
  assign commit    = stable_ok && !committed && (zcnt == 4'd1);
  assign seen_nxt  = seen | ~samp_pos;

  always_ff @(posedge clk_1Hz or posedge rst) begin
    if (rst) begin
      samp_pos   <= 8'hFF;
      samp_seg   <= 8'hFF;
      stab_cnt   <= '0;
      committed  <= 1'b0;
      seen       <= '0;
      tcnt       <= '0;
      digit      <= 32'hFFFF_FFFF;
      dot        <= '0;
      valid      <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      samp_pos <= pos;
      samp_seg <= segments;
      // A new run starts with committed clear, even on the edge that commits the old one.
      if (same) begin
        if (stab_cnt != 4'hF) stab_cnt <= stab_cnt + 4'd1;
        committed <= committed | commit;
      end else begin
        stab_cnt  <= '0;
        committed <= 1'b0;
      end

      err        <= err | (zcnt > 4'd1) | (commit & dec_ill);
      frame_done <= 1'b0;

      if (commit) begin
        digit[{idx, 2'b00} +: 4] <= dec_digit;
        dot[idx]   <= dec_dot;
        valid[idx] <= 1'b1;
        tcnt       <= '0;
        if (seen_nxt == 8'hFF) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end else if (tcnt == TMAX) begin
        valid <= '0;
        seen  <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Two decoder instances (STABLE 1/TIMEOUT 16 and STABLE 3/TIMEOUT 32) driven with the same scan traffic.
// A run-length based reference model is compared against both every cycle, plus literal spot checks.
module tb_seven_segment_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pos, segments;
  logic [31:0] digit_a, digit_b;
  logic [7:0]  dot_a, dot_b, valid_a, valid_b;
  logic        frame_a, frame_b, err_a, err_b;

  int tests = 0;
  int fails = 0;
  int frames_a = 0;

  seven_segment_decoder #(.STABLE_CYCLES(1), .TIMEOUT_CYCLES(16)) u_a (
    .clk_1Hz(clk), .rst(rst), .pos(pos), .segments(segments),
    .digit(digit_a), .dot(dot_a), .valid(valid_a), .frame_done(frame_a), .err(err_a));

  seven_segment_decoder #(.STABLE_CYCLES(3), .TIMEOUT_CYCLES(32)) u_b (
    .clk_1Hz(clk), .rst(rst), .pos(pos), .segments(segments),
    .digit(digit_b), .dot(dot_b), .valid(valid_b), .frame_done(frame_b), .err(err_b));

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic int stable_of(int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic int timeout_of(int m);
    return (m == 0) ? 16 : 32;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a commit happens when the run of identical samples first reaches
  // the stability length; timeout is measured as cycles elapsed since the last commit.
  logic [31:0] m_digit [2];
  logic [7:0]  m_dot [2], m_valid [2], m_seen [2];
  logic        m_frame [2], m_err [2];
  int          run_len [2], since [2];
  logic [15:0] last [2];

  always @(posedge clk or posedge rst) begin
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_digit[m] = 32'hFFFF_FFFF;
        m_dot[m] = '0; m_valid[m] = '0; m_seen[m] = '0;
        m_frame[m] = 1'b0; m_err[m] = 1'b0;
        run_len[m] = 1; since[m] = 0;
        last[m] = 16'hFFFF;
      end else begin
        logic [7:0] p, s;
        int zeros, ix, val;
        logic ill, dt;
        p = last[m][15:8];
        s = last[m][7:0];
        zeros = 0; ix = 0;
        for (int i = 0; i < 8; i++) if (!p[i]) begin zeros++; ix = i; end
        if (zeros >= 2) m_err[m] = 1'b1;
        m_frame[m] = 1'b0;
        if (zeros == 1 && run_len[m] == stable_of(m)) begin
          val = 14; ill = 1'b1;
          for (int d = 0; d < 10; d++) if (enc(d) == s[7:1]) begin val = d; ill = 1'b0; end
          if (s[7:1] == 7'h7F) begin val = 15; ill = 1'b0; end
          dt = (val == 15) ? 1'b0 : ~s[0];
          if (ill) m_err[m] = 1'b1;
          m_digit[m][ix*4 +: 4] = 4'(val);
          m_dot[m][ix] = dt;
          m_valid[m][ix] = 1'b1;
          m_seen[m][ix] = 1'b1;
          since[m] = 0;
          if (m_seen[m] == 8'hFF) begin
            m_frame[m] = 1'b1;
            m_seen[m] = '0;
          end
        end else begin
          since[m]++;
          if (since[m] >= timeout_of(m)) begin
            m_valid[m] = '0;
            m_seen[m] = '0;
          end
        end
        if ({pos, segments} == last[m]) run_len[m]++;
        else run_len[m] = 1;
        last[m] = {pos, segments};
      end
    end
  end

  always @(negedge clk) begin
    if (frame_a === 1'b1) frames_a++;
    check("cycle_a", {14'd0, digit_a, dot_a, valid_a, frame_a, err_a},
          {14'd0, m_digit[0], m_dot[0], m_valid[0], m_frame[0], m_err[0]});
    check("cycle_b", {14'd0, digit_b, dot_b, valid_b, frame_b, err_b},
          {14'd0, m_digit[1], m_dot[1], m_valid[1], m_frame[1], m_err[1]});
  end

  task automatic drive(input logic [7:0] p, input logic [7:0] s, input int n);
    pos = p;
    segments = s;
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic scan(input int npos);
    for (int i = 0; i < npos; i++)
      drive(~(8'h01 << i), {enc(i), (i == 0) ? 1'b0 : 1'b1}, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_digit", 64'(digit_a), 64'h0000_0000_FFFF_FFFF);
    check("rst_flags", 64'({dot_a, valid_a, frame_a, err_a, dot_b, valid_b, frame_b, err_b}), 64'd0);
    @(posedge clk) #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pos = 8'hFF;
    segments = 8'hFF;
    @(posedge clk) #1;
    check("rst_digit_b", 64'(digit_b), 64'h0000_0000_FFFF_FFFF);
    rst = 1'b0;

    // Driver-style scan, three frames, dot on position 0 only.
    frames_a = 0;
    scan(8); scan(8); scan(8);
    drive(8'hFF, 8'hFF, 2);
    check("scan_digit", 64'(digit_a), 64'h7654_3210);
    check("scan_dot", 64'(dot_a), 64'h01);
    check("scan_valid", 64'(valid_a), 64'hFF);
    check("scan_frames", 64'(frames_a), 64'd3);
    check("scan_b_none", 64'(valid_b), 64'd0);

    // Stability: a 2-edge run must not commit with STABLE_CYCLES=3, a 3-edge run must.
    drive(8'hFB, 8'b0010_0101, 2);
    drive(8'hFF, 8'hFF, 1);
    check("short_run", 64'(valid_b[2]), 64'd0);
    drive(8'hFB, 8'b0010_0101, 3);
    drive(8'hFF, 8'hFF, 1);
    check("run_digit", 64'(digit_b[11:8]), 64'd2);
    check("run_dot_valid", 64'({dot_b[2], valid_b[2]}), 64'b01);

    // Multi-hot strobe then a legal pattern: error stays sticky, commit still happens.
    drive(8'hFC, 8'b1001_1111, 3);
    check("multi_err", 64'({err_a, err_b}), 64'b11);
    drive(8'hFE, 8'b1001_1111, 3);
    drive(8'hFF, 8'hFF, 1);
    check("after_err_digit", 64'(digit_b[3:0]), 64'd1);
    check("after_err_err", 64'(err_b), 64'd1);

    // Illegal pattern then blank on position 7.
    drive(8'h7F, 8'b1010_1011, 3);
    drive(8'hFF, 8'hFF, 1);
    check("illegal_digit", 64'(digit_b[31:28]), 64'hE);
    drive(8'h7F, 8'hFF, 3);
    drive(8'hFF, 8'hFF, 1);
    check("blank_digit", 64'({digit_b[31:28], dot_b[7]}), 64'h1E);

    // Timeout: valid drops exactly 16 edges after the last commit on instance a.
    scan(8);
    drive(8'hFF, 8'hFF, 1);
    drive(8'hFF, 8'hFF, 15);
    check("timeout_hold", 64'(valid_a), 64'hFF);
    drive(8'hFF, 8'hFF, 1);
    check("timeout_drop", 64'(valid_a), 64'd0);
    check("timeout_keep", 64'(digit_a), 64'h7654_3210);

    // Reset mid-frame, then a full frame gives exactly one pulse.
    scan(5);
    do_reset();
    frames_a = 0;
    scan(8);
    drive(8'hFF, 8'hFF, 2);
    check("post_rst_frames", 64'(frames_a), 64'd1);

    // Randomised traffic against the model.
    repeat (300) begin
      int r;
      logic [7:0] p, s;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
      end else if (r < 6) begin
        drive(8'hFF, 8'($urandom), $urandom_range(20, 40));
      end else begin
        p = ~(8'h01 << $urandom_range(0, 7));
        if (r < 10) p = p & ~(8'h01 << $urandom_range(0, 7));
        s = {enc($urandom_range(0, 10)), 1'($urandom_range(0, 1))};
        if (r >= 10 && r < 16) s = 8'($urandom);
        drive(p, s, $urandom_range(1, 5));
      end
    end
    drive(8'hFF, 8'hFF, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
